// File: rtl/i2s_tx_serializer_pkg.sv
// Shared I2S audio definitions: Philips-format slot geometry reused by the TX, RX and ASRC blocks.
package i2s_tx_serializer_pkg;
  localparam int I2S_SLOT_WIDTH   = 32;
  localparam int I2S_SAMPLE_WIDTH = 24;
  localparam int I2S_WS_LEAD      = 1;
  localparam int I2S_BCK_HALF     = 2;

  // Word select for frame bit b: WS switches I2S_WS_LEAD bits ahead of each slot.
  function automatic logic i2s_ws(input int b, input int slot_w);
    return (b >= slot_w - I2S_WS_LEAD) && (b <= 2 * slot_w - 1 - I2S_WS_LEAD);
  endfunction
endpackage

// File: rtl/i2s_bck_gen.sv
// ASCLK divider: toggles the bit clock every BCK_HALF AMCLK cycles and flags the falling edge.
// fall_o is combinational and coincides with the AMCLK edge on which ASCLK drops.
module i2s_bck_gen #(
  parameter int BCK_HALF = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic bck_o,
  output logic fall_o
);
  localparam int            DW       = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_HALF - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bck_q, bck_d;
  logic          wrap;

  assign wrap   = (div_cnt_q == DIV_LAST);
  assign fall_o = wrap && bck_q;
  assign bck_o  = bck_q;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    bck_d     = bck_q;
    if (wrap) begin
      div_cnt_d = '0;
      bck_d     = ~bck_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
    end
  end
endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo PCM to Philips I2S transmitter with a one-pair holding register; a pair accepted
// now goes out at the next frame start (<= 1 frame + 1 AMCLK), ready stays low while the holding is full.
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
  parameter int BCK_HALF     = I2S_BCK_HALF
) (
  input  logic                    AMCLK_i,
  input  logic                    nARST,
  input  logic [SAMPLE_WIDTH-1:0] sample_l_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_r_i,
  input  logic                    sample_valid_i,
  output logic                    sample_ready_o,
  output logic                    ASCLK_o,
  output logic                    ALRCLK_o,
  output logic                    ASDATA_o,
  output logic                    frame_start_o,
  output logic                    underrun_o
);
  localparam int            FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int            BW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  logic                    fall, load, accept;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [FRAME_BITS-1:0]   shift_q, shift_d, frame_word;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                    hold_full_q, hold_full_d, ready_q;
  logic                    ws_q, ws_d, data_q, data_d, fs_q, ur_q;

  i2s_bck_gen #(.BCK_HALF(BCK_HALF)) u_bck_gen (
    .clk_i  (AMCLK_i),
    .rst_ni (nARST),
    .bck_o  (ASCLK_o),
    .fall_o (fall)
  );

  assign bit_nxt = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
  assign load    = fall && (bit_nxt == '0);
  assign accept  = sample_valid_i && ready_q;

  // Whole frame laid out MSB-first: left slot then right slot, each zero-padded at the tail.
  always_comb begin
    frame_word = '0;
    frame_word[FRAME_BITS-1 -: SAMPLE_WIDTH] = hold_full_q ? hold_l_q : '0;
    frame_word[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = hold_full_q ? hold_r_q : '0;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ws_d        = ws_q;
    data_d      = data_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    if (fall) begin
      bit_cnt_d = bit_nxt;
      ws_d      = i2s_ws(int'(bit_nxt), SLOT_WIDTH);
      if (load) begin
        data_d      = frame_word[FRAME_BITS-1];
        shift_d     = frame_word << 1;
        hold_full_d = 1'b0;
      end else begin
        data_d  = shift_q[FRAME_BITS-1];
        shift_d = shift_q << 1;
      end
    end
    // Accept only happens with the holding empty, so it never races a load of valid data.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = sample_l_i;
      hold_r_d    = sample_r_i;
    end
  end

  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      bit_cnt_q   <= BIT_LAST;
      shift_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      ws_q        <= 1'b0;
      data_q      <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      ws_q        <= ws_d;
      data_q      <= data_d;
      fs_q        <= load;
      ur_q        <= load && !hold_full_q;
    end
  end

  assign sample_ready_o = ready_q;
  assign ALRCLK_o       = ws_q;
  assign ASDATA_o       = data_q;
  assign frame_start_o  = fs_q;
  assign underrun_o     = ur_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: random sample pairs, a bit-level I2S receiver model and a
// frame-level expectation queue built from edge arithmetic since reset release.
module tb_i2s_tx_serializer;
  localparam int SW    = 24;
  localparam int S     = 32;
  localparam int BH    = 2;
  localparam int FRAME = 2 * S * 2 * BH;
  localparam int F0    = 2 * BH;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [SW-1:0] l_i   = '0;
  logic [SW-1:0] r_i   = '0;
  logic          vld_i = 1'b0;
  logic          rdy_o, asclk_o, alrclk_o, asdata_o, fs_o, ur_o;

  i2s_tx_serializer #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(S), .BCK_HALF(BH)) dut (
    .AMCLK_i        (clk),
    .nARST          (rst_n),
    .sample_l_i     (l_i),
    .sample_r_i     (r_i),
    .sample_valid_i (vld_i),
    .sample_ready_o (rdy_o),
    .ASCLK_o        (asclk_o),
    .ALRCLK_o       (alrclk_o),
    .ASDATA_o       (asdata_o),
    .frame_start_o  (fs_o),
    .underrun_o     (ur_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef enum int {M_IDLE, M_ONE, M_STREAM, M_EDGE} mode_t;
  mode_t mode = M_IDLE;

  int              n;
  bit              m_full, acc_pend, one_pend, edge_armed, prev_bck;
  logic [SW-1:0]   m_l, m_r, acc_l, acc_r, one_l, one_r, seq;
  logic [2*SW-1:0] exp_q[$];

  bit            rx_prev_ws, rx_pend, rx_pend_ch, rx_ch, rx_aligned, rx_have_left;
  int            rx_pos;
  int            rx_frames = 0;
  int            rx_pad_err = 0;
  int            rx_slot_err = 0;
  logic [SW-1:0] rx_word, rx_left;

  function automatic bit is_frame_edge(input int e);
    return (e >= F0) && ((e - F0) % FRAME == 0);
  endfunction

  function automatic int cur_bit(input int e);
    return (e < F0) ? 2 * S - 1 : ((e - F0) / (2 * BH)) % (2 * S);
  endfunction

  task automatic model_init();
    n = 0; m_full = 0; acc_pend = 0; prev_bck = 0;
    exp_q.delete();
    rx_prev_ws = 1; rx_pend = 0; rx_pos = -1; rx_aligned = 0; rx_have_left = 0; rx_word = '0;
  endtask

  task automatic frame_done(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [2*SW-1:0] e;
    rx_frames++;
    chk("rx_unexpected_frame", exp_q.size() == 0, 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rx_left", l, e[2*SW-1:SW]);
      chk("rx_right", r, e[SW-1:0]);
    end
  endtask

  // Philips receiver: a WS change seen on a BCK rise opens the other channel's slot one bit later.
  task automatic rx_bit(input bit ws, input bit d);
    if (rx_pend) begin
      if (rx_aligned && rx_pos != -1) rx_slot_err++;
      rx_ch = rx_pend_ch; rx_pos = 0; rx_word = '0; rx_pend = 0; rx_aligned = 1;
    end
    if (rx_pos >= 0) begin
      if (rx_pos < SW) rx_word = {rx_word[SW-2:0], d};
      else if (d) rx_pad_err++;
      rx_pos++;
      if (rx_pos == S) begin
        if (!rx_ch) begin
          rx_left = rx_word; rx_have_left = 1;
        end else begin
          if (rx_have_left) frame_done(rx_left, rx_word);
          rx_have_left = 0;
        end
        rx_pos = -1;
      end
    end else if (rx_aligned) begin
      rx_slot_err++;
    end
    if (ws != rx_prev_ws) begin
      rx_pend = 1; rx_pend_ch = ws;
    end
    rx_prev_ws = ws;
  endtask

  task automatic drive();
    vld_i = 0;
    l_i   = SW'($urandom);
    r_i   = SW'($urandom);
    case (mode)
      M_ONE:    if (one_pend) begin vld_i = 1; l_i = one_l; r_i = one_r; end
      M_STREAM: begin vld_i = 1; l_i = seq; end
      M_EDGE:   if (edge_armed && is_frame_edge(n + 1)) vld_i = 1;
      default:  ;
    endcase
    if (vld_i && rdy_o) begin
      acc_pend = 1; acc_l = l_i; acc_r = r_i;
      if (mode == M_ONE) one_pend = 0;
      if (mode == M_STREAM) seq = seq + 1'b1;
      if (mode == M_EDGE) edge_armed = 0;
    end
  endtask

  task automatic step();
    bit fs_exp, ur_exp;
    int b;
    @(posedge clk);
    n++;
    @(negedge clk);
    fs_exp = is_frame_edge(n);
    ur_exp = fs_exp && !m_full;
    if (fs_exp) begin
      exp_q.push_back(m_full ? {m_l, m_r} : '0);
      m_full = 0;
    end
    if (acc_pend) begin
      m_full = 1; m_l = acc_l; m_r = acc_r; acc_pend = 0;
    end
    b = cur_bit(n);
    chk("frame_start", fs_o, fs_exp);
    chk("underrun", ur_o, ur_exp);
    chk("ready", rdy_o, !m_full);
    chk("asclk", asclk_o, (n / BH) % 2);
    chk("alrclk", alrclk_o, (b >= S - 1) && (b <= 2 * S - 2));
    if (asclk_o && !prev_bck) rx_bit(alrclk_o, asdata_o);
    prev_bck = asclk_o;
    drive();
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 0;
    vld_i = 0;
    #1;
    chk("rst_asclk", asclk_o, 0);
    chk("rst_alrclk", alrclk_o, 0);
    chk("rst_asdata", asdata_o, 0);
    chk("rst_frame_start", fs_o, 0);
    chk("rst_underrun", ur_o, 0);
    chk("rst_ready", rdy_o, 1);
    repeat (hold) @(negedge clk);
    chk("rst_ready_held", rdy_o, 1);
    chk("rst_asclk_held", asclk_o, 0);
    rst_n = 1;
    model_init();
  endtask

  initial begin
    bit found;
    model_init();
    seq = 1;
    #2 do_reset(3);

    mode = M_IDLE;
    run(F0 + 8);

    one_l = 24'hA5A5A5; one_r = 24'h5A5A5A; one_pend = 1;
    mode = M_ONE;
    run(3 * FRAME);

    for (int i = 0; i < 2; i++) begin
      one_l = SW'($urandom); one_r = SW'($urandom); one_pend = 1;
      run(FRAME);
    end

    mode = M_STREAM;
    run(6 * FRAME);

    mode = M_IDLE;
    run(FRAME + FRAME / 2);
    edge_armed = 1;
    mode = M_EDGE;
    run(FRAME);
    chk("edge_write_taken", edge_armed, 0);
    mode = M_STREAM;
    run(3 * FRAME);

    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (cur_bit(n) == 40 && m_full) found = 1;
    end
    chk("mid_frame_point_reached", found, 1);
    do_reset(2);
    mode = M_IDLE;
    run(2 * FRAME + F0);

    chk("rx_frames_min", rx_frames >= 14, 1);
    chk("rx_pad_bits_zero", rx_pad_err, 0);
    chk("rx_slot_length", rx_slot_err, 0);
    chk("exp_backlog", exp_q.size() <= 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
